// File: rtl/linebuffer_kxk_stream_if.sv
// Stream bundle for the KxK line buffer: pixel input side plus window output side.
interface linebuffer_kxk_stream_if #(
  parameter int DW    = 4,
  parameter int K     = 2,
  parameter int MAX_W = 32
);
  localparam int AW = $clog2(MAX_W + 1);

  logic              frame_start;
  logic [AW-1:0]     img_w;
  logic              stride2;
  logic              in_valid;
  logic [DW-1:0]     pix_in;
  logic              out_valid;
  logic [K*K*DW-1:0] win_out;
  logic              out_row_end;
  logic              cfg_err;

  modport master (
    output frame_start, img_w, stride2, in_valid, pix_in,
    input  out_valid, win_out, out_row_end, cfg_err
  );

  modport slave (
    input  frame_start, img_w, stride2, in_valid, pix_in,
    output out_valid, win_out, out_row_end, cfg_err
  );
endinterface

// File: rtl/linebuffer_kxk_stream.sv
// Raster-stream line buffer: keeps K-1 previous lines and emits a KxK window per
// accepted beat (stride 1) or per even-offset row/column (stride 2).
module linebuffer_kxk_stream #(
  parameter int DW    = 4,
  parameter int K     = 2,
  parameter int MAX_W = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  linebuffer_kxk_stream_if.slave  bus
);
  localparam int AW = $clog2(MAX_W + 1);
  localparam int MA = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [AW-1:0] K_A    = AW'(K);
  localparam logic [AW-1:0] KM1_A  = AW'(K - 1);
  localparam logic [AW-1:0] MAXW_A = AW'(MAX_W);
  localparam logic [15:0]   KM1_R  = 16'(K - 1);

  logic [DW-1:0] r_lb [K-1][2**MA];
  logic [K-1:0][K-1:0][DW-1:0] r_win, w_win_next;

  logic [AW-1:0]     r_col, r_w_lat;
  logic [15:0]       r_row;
  logic              r_s2, r_cfg_err, r_out_valid, r_out_row_end;
  logic [K*K*DW-1:0] r_win_out;

  logic [AW-1:0] w_col, w_w, w_last, w_last_s2, w_wmk, w_col_off;
  logic [15:0]   w_row, w_row_off;
  logic          w_s2, w_err, w_img_bad, w_win_ok, w_row_end;
  logic [MA-1:0] w_addr;

  // A frame_start beat already belongs to the new frame, so use the incoming config.
  assign w_img_bad = (bus.img_w < K_A) || (bus.img_w > MAXW_A);
  assign w_col     = bus.frame_start ? '0 : r_col;
  assign w_row     = bus.frame_start ? '0 : r_row;
  assign w_w       = bus.frame_start ? bus.img_w : r_w_lat;
  assign w_s2      = bus.frame_start ? bus.stride2 : r_s2;
  assign w_err     = bus.frame_start ? w_img_bad : r_cfg_err;
  assign w_addr    = w_col[MA-1:0];

  assign w_last    = w_w - AW'(1);
  assign w_wmk     = w_w - K_A;
  assign w_last_s2 = w_wmk[0] ? (w_w - AW'(2)) : w_last;
  assign w_col_off = w_col - KM1_A;
  assign w_row_off = w_row - KM1_R;

  assign w_win_ok  = !w_err && (w_row >= KM1_R) && (w_col >= KM1_A) &&
                     (!w_s2 || (!w_col_off[0] && !w_row_off[0]));
  assign w_row_end = w_s2 ? (w_col == w_last_s2) : (w_col == w_last);

  always_comb begin
    w_win_next = r_win;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K - 1; c++)
        w_win_next[r][c] = r_win[r][c+1];
    for (int r = 0; r < K - 1; r++)
      w_win_next[r][K-1] = r_lb[K-2-r][w_addr];
    w_win_next[K-1][K-1] = bus.pix_in;
  end

  // Line memories are never cleared; window validity gating hides stale contents.
  always_ff @(posedge i_clk) begin
    if (bus.in_valid) begin
      r_lb[0][w_addr] <= bus.pix_in;
      for (int i = 1; i < K - 1; i++)
        r_lb[i][w_addr] <= r_lb[i-1][w_addr];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_col         <= '0;
      r_row         <= '0;
      r_w_lat       <= MAXW_A;
      r_s2          <= 1'b0;
      r_cfg_err     <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_row_end <= 1'b0;
      r_win         <= '0;
      r_win_out     <= '0;
    end else begin
      r_out_valid   <= 1'b0;
      r_out_row_end <= 1'b0;
      if (bus.frame_start) begin
        r_w_lat   <= bus.img_w;
        r_s2      <= bus.stride2;
        r_cfg_err <= w_img_bad;
        r_col     <= '0;
        r_row     <= '0;
      end
      if (bus.in_valid) begin
        r_win <= w_win_next;
        if (w_col == w_last) begin
          r_col <= '0;
          r_row <= (w_row == 16'hFFFF) ? w_row : w_row + 16'd1;
        end else begin
          r_col <= w_col + AW'(1);
          r_row <= w_row;
        end
        if (w_win_ok) begin
          r_out_valid   <= 1'b1;
          r_out_row_end <= w_row_end;
          r_win_out     <= w_win_next;
        end
      end
    end
  end

  assign bus.out_valid   = r_out_valid;
  assign bus.out_row_end = r_out_row_end;
  assign bus.win_out     = r_win_out;
  assign bus.cfg_err     = r_cfg_err;
endmodule

// File: tb/tb_linebuffer_kxk_stream.sv
// Bench for the KxK line buffer: image-indexed reference model plus literal window checks,
// with one K=2 and one K=3 instance.
module tb_linebuffer_kxk_stream;
  localparam int DW = 4;
  localparam int MW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  linebuffer_kxk_stream_if #(.DW(DW), .K(2), .MAX_W(MW)) if0 ();
  linebuffer_kxk_stream_if #(.DW(DW), .K(3), .MAX_W(MW)) if1 ();

  linebuffer_kxk_stream #(.DW(DW), .K(2), .MAX_W(MW)) u0 (.i_clk(clk), .i_rst(rst), .bus(if0.slave));
  linebuffer_kxk_stream #(.DW(DW), .K(3), .MAX_W(MW)) u1 (.i_clk(clk), .i_rst(rst), .bus(if1.slave));

  typedef struct {
    logic [63:0] win;
    logic        re;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int          cyc = 0;
  int          n_pass = 0;
  int          n_tot = 0;
  int          m_w[2];
  int          m_n[2];
  bit          m_s2[2];
  bit          m_err[2];
  int          m_img[2][256];
  logic [63:0] last_win[2];
  int          cnt[2];
  logic [63:0] first_act[2];
  logic [63:0] last_act[2];
  logic        last_re[2];
  logic [63:0] log_win[$];
  logic        log_re[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
  endtask

  function automatic int kof(input int sel);
    return (sel == 0) ? 2 : 3;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_w[s] = MW; m_n[s] = 0; m_s2[s] = 0; m_err[s] = 0; last_win[s] = '0;
    end
    q0.delete();
    q1.delete();
  endtask

  // One accepted edge worth of reference behaviour, in image coordinates.
  task automatic model_beat(input int sel, input bit fs, input int w, input bit s2,
                            input bit v, input int pix);
    int kk, row, col;
    exp_t e;
    kk = kof(sel);
    if (fs) begin
      m_w[sel] = w; m_s2[sel] = s2; m_n[sel] = 0;
      m_err[sel] = (w < kk) || (w > MW);
    end
    if (v) begin
      row = m_n[sel] / m_w[sel];
      col = m_n[sel] % m_w[sel];
      if (m_n[sel] < 256) m_img[sel][m_n[sel]] = pix;
      m_n[sel]++;
      if (!m_err[sel] && row >= kk - 1 && col >= kk - 1 &&
          (!m_s2[sel] || (((row - kk + 1) % 2 == 0) && ((col - kk + 1) % 2 == 0)))) begin
        e.win = '0;
        for (int r = 0; r < kk; r++)
          for (int c = 0; c < kk; c++)
            e.win[(r*kk+c)*4 +: 4] = 4'(m_img[sel][(row-kk+1+r)*m_w[sel] + col-kk+1+c]);
        e.re  = m_s2[sel] ? (col + 2 > m_w[sel] - 1) : (col == m_w[sel] - 1);
        e.due = cyc + 1;
        if (sel == 0) q0.push_back(e);
        else          q1.push_back(e);
      end
    end
  endtask

  task automatic drive(input int sel, input bit fs, input int w, input bit s2,
                       input bit v, input int pix);
    @(posedge clk);
    #1;
    if0.frame_start = (sel == 0) && fs;  if0.in_valid = (sel == 0) && v;
    if1.frame_start = (sel == 1) && fs;  if1.in_valid = (sel == 1) && v;
    if0.img_w = 4'(w); if0.stride2 = s2; if0.pix_in = 4'(pix);
    if1.img_w = 4'(w); if1.stride2 = s2; if1.pix_in = 4'(pix);
    model_beat(sel, fs, w, s2, v, pix);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic clear_cnt();
    cnt[0] = 0; cnt[1] = 0;
    log_win.delete();
    log_re.delete();
  endtask

  task automatic chk(input int sel, input logic ov, input logic [63:0] win, input logic re);
    exp_t e;
    bit   have;
    have = 0;
    e.win = '0; e.re = 0; e.due = 0;
    if (sel == 0 && q0.size() > 0) if (q0[0].due == cyc) begin e = q0.pop_front(); have = 1; end
    if (sel == 1 && q1.size() > 0) if (q1[0].due == cyc) begin e = q1.pop_front(); have = 1; end
    if (have) begin
      check($sformatf("pulse%0d", sel), 64'(ov), 64'd1);
      if (ov) begin
        check($sformatf("win%0d", sel), win, e.win);
        check($sformatf("row_end%0d", sel), 64'(re), 64'(e.re));
      end
      last_win[sel] = e.win;
    end else begin
      check($sformatf("no_pulse%0d", sel), 64'(ov), 64'd0);
      check($sformatf("hold%0d", sel), win, last_win[sel]);
    end
    if (ov) begin
      cnt[sel]++;
      if (cnt[sel] == 1) first_act[sel] = win;
      last_act[sel] = win;
      last_re[sel]  = re;
      if (sel == 0) begin log_win.push_back(win); log_re.push_back(re); end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk(0, if0.out_valid, 64'(if0.win_out), if0.out_row_end);
      chk(1, if1.out_valid, 64'(if1.win_out), if1.out_row_end);
    end
  end

  task automatic check_zero(input string nm);
    check({nm, "_ov0"},  64'(if0.out_valid), 64'd0);
    check({nm, "_win0"}, 64'(if0.win_out), 64'd0);
    check({nm, "_re0"},  64'(if0.out_row_end), 64'd0);
    check({nm, "_err0"}, 64'(if0.cfg_err), 64'd0);
    check({nm, "_ov1"},  64'(if1.out_valid), 64'd0);
    check({nm, "_win1"}, 64'(if1.win_out), 64'd0);
  endtask

  task automatic check_t1(input string nm);
    check({nm, "_count"}, 64'(cnt[0]), 64'd9);
    check({nm, "_first"}, first_act[0], 64'h5410);
    check({nm, "_last"},  last_act[0], 64'hFEBA);
    check({nm, "_last_re"}, 64'(last_re[0]), 64'd1);
  endtask

  initial begin
    bit pat[8];
    int p, k;
    logic [63:0] s2_exp[4];

    if0.frame_start = 0; if0.in_valid = 0; if0.img_w = 0; if0.stride2 = 0; if0.pix_in = 0;
    if1.frame_start = 0; if1.in_valid = 0; if1.img_w = 0; if1.stride2 = 0; if1.pix_in = 0;
    model_reset();
    clear_cnt();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 0;

    // Test 1: stride 1, width 4
    clear_cnt();
    drive(0, 1, 4, 0, 0, 0);
    for (int i = 0; i < 16; i++) drive(0, 0, 0, 0, 1, i);
    idle(3);
    check_t1("t1");

    // Test 2: stride 2
    clear_cnt();
    drive(0, 1, 4, 1, 0, 0);
    for (int i = 0; i < 16; i++) drive(0, 0, 0, 0, 1, i);
    idle(3);
    check("t2_count", 64'(log_win.size()), 64'd4);
    s2_exp[0] = 64'h5410; s2_exp[1] = 64'h7632; s2_exp[2] = 64'hDC98; s2_exp[3] = 64'hFEBA;
    if (log_win.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("t2_win%0d", i), log_win[i], s2_exp[i]);
        check($sformatf("t2_re%0d", i), 64'(log_re[i]), 64'(i % 2));
      end
    end

    // Test 3: irregular in_valid
    clear_cnt();
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1; pat[5] = 0; pat[6] = 1; pat[7] = 0;
    drive(0, 1, 4, 0, 0, 0);
    p = 0; k = 0;
    while (p < 16 && k < 200) begin
      drive(0, 0, 0, 0, pat[k % 8], p);
      if (pat[k % 8]) p++;
      k++;
    end
    idle(3);
    check_t1("t3");

    // Test 4: K=3, width 5
    clear_cnt();
    drive(1, 1, 5, 0, 0, 0);
    for (int i = 0; i < 25; i++) drive(1, 0, 0, 0, 1, i % 16);
    idle(3);
    check("t4_count", 64'(cnt[1]), 64'd9);
    check("t4_first", first_act[1], 64'h0_CBA7_6521_0);
    check("t4_last",  last_act[1],  64'h8_7632_1EDC);
    check("t4_last_re", 64'(last_re[1]), 64'd1);

    // Test 5: illegal widths
    clear_cnt();
    drive(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) drive(0, 0, 0, 0, 1, i);
    idle(2);
    check("t5_err_w1", 64'(if0.cfg_err), 64'd1);
    check("t5_cnt_w1", 64'(cnt[0]), 64'd0);
    drive(0, 1, 9, 0, 0, 0);
    for (int i = 0; i < 16; i++) drive(0, 0, 0, 0, 1, i);
    idle(2);
    check("t5_err_w9", 64'(if0.cfg_err), 64'd1);
    check("t5_cnt_w9", 64'(cnt[0]), 64'd0);
    drive(0, 1, 4, 0, 0, 0);
    idle(1);
    check("t5_err_clear", 64'(if0.cfg_err), 64'd0);

    // Test 6: reset mid-frame, then frame_start coincident with pixel 0
    clear_cnt();
    drive(0, 1, 4, 0, 0, 0);
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 1, i);
    @(posedge clk);
    #1;
    rst = 1;
    if0.in_valid = 0; if0.frame_start = 0;
    model_reset();
    #1;
    check_zero("t6_rst");
    repeat (2) @(posedge clk);
    #1;
    check_zero("t6_rst_hold");
    rst = 0;
    clear_cnt();
    drive(0, 1, 4, 0, 1, 0);
    for (int i = 1; i < 16; i++) drive(0, 0, 0, 0, 1, i);
    idle(3);
    check_t1("t6");

    check("drain_q0", 64'(q0.size()), 64'd0);
    check("drain_q1", 64'(q1.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
